// File: rtl/pipe_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg -- shared types and constants for the pipeline scoreboard.
//
// Holds the default sizing of the scoreboard (32 registers, results at most
// 4 cycles away), the register index and latency types derived from that
// sizing, and the standard latencies of the execution units.
//
// Configuration macro used by the scoreboard: PIPE_SCOREBOARD_BYPASS_EN
// (see pipe_scoreboard.sv).
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int REG_COUNT_DEF = 32;
  localparam int MAX_LAT_DEF   = 4;
  localparam int RW_DEF        = $clog2(REG_COUNT_DEF);
  localparam int LW_DEF        = $clog2(MAX_LAT_DEF + 1);

  typedef logic [RW_DEF-1:0] regIdx_t;
  typedef logic [LW_DEF-1:0] lat_t;

  // Result latencies of the execution units, in cycles until write back.
  localparam lat_t LAT_ALU  = lat_t'(1);
  localparam lat_t LAT_LOAD = lat_t'(2);
  localparam lat_t LAT_MUL  = lat_t'(MAX_LAT_DEF);

endpackage

// File: rtl/pipe_scoreboard_counter.sv
// ---------------------------------------------------------------------------
// sb_counter -- countdown for one architectural register.
//
// The value is the number of cycles until the register's pending result is
// written back; zero means the register file copy is valid.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset, clears the count
//   load     an accepted issue targets this register
//   loadVal  latency to load (already clamped by the caller)
//   cnt      current count
// ---------------------------------------------------------------------------
module sb_counter #(
  parameter int LW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [LW-1:0] loadVal,
  output logic [LW-1:0] cnt
);

  // A new issue overrides the running countdown; otherwise count down to
  // zero and stay there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// ---------------------------------------------------------------------------
// pipe_scoreboard -- register scoreboard for an in-order pipeline.
//
// Keeps a countdown per architectural register of how many cycles remain
// until its in-flight result is written back, and from that decides whether
// the instruction in ID has to stall (RAW on a source, WAW on the
// destination) or may take a source from the bypass network.
//
// Parameters:
//   REG_COUNT  number of architectural registers (power of two, >= 2)
//   MAX_LAT    largest result latency in cycles (>= 2)
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   issue_valid  ID presents an instruction
//   flush        cancel the current issue (redirect)
//   rs, rt       source register numbers
//   rs_used      rs is actually read
//   rt_used      rt is actually read
//   rd           destination register
//   wr_en        instruction writes rd
//   lat          cycles until the result is written back (1..MAX_LAT)
//   stall        hold PC / IF-ID, bubble ID-EX (combinational)
//   fwd_rs       take rs from the bypass path (combinational)
//   fwd_rt       take rt from the bypass path (combinational)
//   pending      number of registers with a result in flight (registered)
//
// Macro PIPE_SCOREBOARD_BYPASS_EN: when defined, a source whose result is
// one cycle away is forwarded instead of stalling. When undefined, any
// in-flight source stalls and the forward outputs are held low.
// ---------------------------------------------------------------------------
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter  int REG_COUNT = REG_COUNT_DEF,
  parameter  int MAX_LAT   = MAX_LAT_DEF,
  localparam int RW        = $clog2(REG_COUNT),
  localparam int LW        = $clog2(MAX_LAT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  input  logic          flush,
  input  logic [RW-1:0] rs,
  input  logic [RW-1:0] rt,
  input  logic          rs_used,
  input  logic          rt_used,
  input  logic [RW-1:0] rd,
  input  logic          wr_en,
  input  logic [LW-1:0] lat,
  output logic          stall,
  output logic          fwd_rs,
  output logic          fwd_rt,
  output logic [RW:0]   pending
);

  logic [REG_COUNT-1:0][LW-1:0] cntArr;
  logic [LW-1:0]                latEff;
  logic [LW-1:0]                rsCnt;
  logic [LW-1:0]                rtCnt;
  logic [LW-1:0]                rdCnt;
  logic                         rsActive;
  logic                         rtActive;
  logic                         rsHazard;
  logic                         rtHazard;
  logic                         wawHazard;
  logic                         accept;
  logic                         loadEn;
  logic [RW:0]                  nonzeroCount;

  // Out-of-range latencies are treated as the slowest unit so the counters
  // never hold a value the hazard logic was not sized for.
  assign latEff = (lat > LW'(MAX_LAT)) ? LW'(MAX_LAT) : lat;

  // Register 0 is hard-wired, so it never has a result in flight.
  assign cntArr[0] = '0;

  assign rsCnt = cntArr[rs];
  assign rtCnt = cntArr[rt];
  assign rdCnt = cntArr[rd];

  assign rsActive = rs_used && (rs != '0);
  assign rtActive = rt_used && (rt != '0);

`ifdef PIPE_SCOREBOARD_BYPASS_EN
  // A result one cycle away is on the bypass path by the time the consumer
  // reaches EX, so only counts of two or more have to wait.
  assign rsHazard = rsActive && (rsCnt > LW'(1));
  assign rtHazard = rtActive && (rtCnt > LW'(1));
  assign fwd_rs   = rsActive && (rsCnt == LW'(1));
  assign fwd_rt   = rtActive && (rtCnt == LW'(1));
`else
  assign rsHazard = rsActive && (rsCnt != '0);
  assign rtHazard = rtActive && (rtCnt != '0);
  assign fwd_rs   = 1'b0;
  assign fwd_rt   = 1'b0;
`endif

  // A younger write must not land before an older one to the same register.
  assign wawHazard = wr_en && (rd != '0) && (rdCnt > latEff);

  // The hazard checks use the counts as they stand before this issue, so an
  // instruction reading and writing the same register sees the old producer.
  assign stall  = issue_valid && (rsHazard || rtHazard || wawHazard);
  assign accept = issue_valid && !stall && !flush;
  assign loadEn = accept && wr_en && (rd != '0) && (latEff != '0);

  // One countdown per trackable register; the one matching rd is reloaded.
  for (genvar g = 1; g < REG_COUNT; g++) begin : genCnt
    sb_counter #(
      .LW(LW)
    ) uCnt (
      .clk    (clk),
      .rst    (rst),
      .load   (loadEn && (rd == RW'(g))),
      .loadVal(latEff),
      .cnt    (cntArr[g])
    );
  end

  // Population count of registers that still have a result in flight.
  always_comb begin
    nonzeroCount = '0;
    for (int r = 1; r < REG_COUNT; r++) begin
      if (cntArr[r] != '0) begin
        nonzeroCount = nonzeroCount + (RW+1)'(1);
      end
    end
  end

  // The pending count is registered, so it follows the counters one cycle
  // later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= nonzeroCount;
    end
  end

endmodule
